// File: rtl/router_wrr_arbiter.sv
// Packet-level weighted round-robin arbiter for one router output port.
//
// Shares the output between five input FIFOs (0=top, 1=bottom, 2=left, 3=right, 4=ip).
// A wormhole lock is held from the first flit of a packet until its Last flit. Each input
// may win up to cfg_weight packets in a row before the pointer moves on. A weight of 0 is
// treated as 1.
//
// Optional feature (macro ARB_TIMEOUT_EN): a stall monitor that raises the sticky
// stall_err flag after TIMEOUT_CYC consecutive locked cycles without a transfer.
//
// Ports:
//   clk         clock
//   nreset      asynchronous active-low reset
//   req         per-input head-flit present (~empty)
//   last        per-input Last bit of the head flit
//   out_ready   downstream Ready for this output
//   cfg_weight  per-input packets-per-turn, field i at [i*WEIGHT_W +: WEIGHT_W]
//   grant       registered one-hot lock owner
//   grant_idx   binary owner index, valid while busy
//   busy        lock held
//   sel_valid   owner has a flit available
//   rd_en       per-input FIFO pop strobe
//   stall_err   sticky stall flag (ARB_TIMEOUT_EN only)
module router_wrr_arbiter #(
  parameter int unsigned N_REQ    = 5,
  parameter int unsigned WEIGHT_W = 4
`ifdef ARB_TIMEOUT_EN
  , parameter int unsigned TIMEOUT_CYC = 256
`endif
) (
  input  logic                      clk,
  input  logic                      nreset,
  input  logic [N_REQ-1:0]          req,
  input  logic [N_REQ-1:0]          last,
  input  logic                      out_ready,
  input  logic [N_REQ*WEIGHT_W-1:0] cfg_weight,
  output logic [N_REQ-1:0]          grant,
  output logic [2:0]                grant_idx,
  output logic                      busy,
  output logic                      sel_valid,
  output logic [N_REQ-1:0]          rd_en
`ifdef ARB_TIMEOUT_EN
  , output logic                    stall_err
`endif
);

  localparam int unsigned IdxW = 3;

  typedef enum logic [0:0] {StIdle, StLock} state_e;

  state_e              state_q, state_d;
  logic [N_REQ-1:0]    grant_q, grant_d;
  logic [IdxW-1:0]     grant_idx_q, grant_idx_d;
  logic [IdxW-1:0]     ptr_q, ptr_d;
  logic [WEIGHT_W-1:0] used_q, used_d;

  logic                xfer;
  logic                win_found;
  logic [IdxW-1:0]     win_idx;
  logic [WEIGHT_W-1:0] weight_raw;
  logic [WEIGHT_W-1:0] eff;
  logic [WEIGHT_W:0]   used_inc;

  // Explicit wrap so a non-power-of-2 N_REQ never lands on a missing input.
  function automatic logic [IdxW-1:0] wrap_idx(input int unsigned v);
    if (v >= N_REQ) begin
      return IdxW'(v - N_REQ);
    end
    return IdxW'(v);
  endfunction

  // Rotating priority search starting at ptr.
  always_comb begin
    win_found = 1'b0;
    win_idx   = '0;
    for (int unsigned k = 0; k < N_REQ; k++) begin
      if (!win_found && req[wrap_idx(32'(ptr_q) + k)]) begin
        win_found = 1'b1;
        win_idx   = wrap_idx(32'(ptr_q) + k);
      end
    end
  end

  // Weight of the current owner, sampled in the packet-end cycle.
  always_comb begin
    weight_raw = cfg_weight[32'(grant_idx_q) * WEIGHT_W +: WEIGHT_W];
    eff        = (weight_raw == '0) ? WEIGHT_W'(1) : weight_raw;
    // One bit wider so used+1 cannot wrap before the compare.
    used_inc   = {1'b0, used_q} + (WEIGHT_W + 1)'(1);
  end

  // State register.
  always_ff @(posedge clk or negedge nreset) begin
    if (!nreset) begin
      state_q     <= StIdle;
      grant_q     <= '0;
      grant_idx_q <= '0;
      ptr_q       <= '0;
      used_q      <= '0;
    end else begin
      state_q     <= state_d;
      grant_q     <= grant_d;
      grant_idx_q <= grant_idx_d;
      ptr_q       <= ptr_d;
      used_q      <= used_d;
    end
  end

  // Next-state logic.
  always_comb begin
    state_d     = state_q;
    grant_d     = grant_q;
    grant_idx_d = grant_idx_q;
    ptr_d       = ptr_q;
    used_d      = used_q;
    unique case (state_q)
      StIdle: begin
        if (win_found) begin
          state_d          = StLock;
          grant_d          = '0;
          grant_d[win_idx] = 1'b1;
          grant_idx_d      = win_idx;
          // Turn passes to a different input: its packet budget starts fresh.
          if (win_idx != ptr_q) begin
            used_d = '0;
          end
        end
      end
      StLock: begin
        if (xfer && last[grant_idx_q]) begin
          state_d = StIdle;
          grant_d = '0;
          if (used_inc >= {1'b0, eff}) begin
            ptr_d  = wrap_idx(32'(grant_idx_q) + 32'd1);
            used_d = '0;
          end else begin
            ptr_d  = grant_idx_q;
            used_d = used_inc[WEIGHT_W-1:0];
          end
        end
      end
      default: begin
        state_d = StIdle;
        grant_d = '0;
      end
    endcase
  end

  // Outputs. busy is 0 in reset, which forces sel_valid and rd_en low too.
  always_comb begin
    busy      = (state_q == StLock);
    sel_valid = busy & req[grant_idx_q];
    xfer      = sel_valid & out_ready;
    rd_en     = grant_q & {N_REQ{xfer}};
    grant     = grant_q;
    grant_idx = grant_idx_q;
  end

`ifdef ARB_TIMEOUT_EN
  localparam int unsigned CntW = $clog2(TIMEOUT_CYC + 1);

  logic [CntW-1:0] stall_cnt_q, stall_cnt_d;
  logic            stall_err_q, stall_err_d;

  always_comb begin
    stall_cnt_d = stall_cnt_q;
    if (!busy || xfer) begin
      stall_cnt_d = '0;
    end else if (stall_cnt_q != CntW'(TIMEOUT_CYC)) begin
      stall_cnt_d = stall_cnt_q + CntW'(1);
    end
    stall_err_d = stall_err_q | (stall_cnt_d == CntW'(TIMEOUT_CYC));
  end

  always_ff @(posedge clk or negedge nreset) begin
    if (!nreset) begin
      stall_cnt_q <= '0;
      stall_err_q <= 1'b0;
    end else begin
      stall_cnt_q <= stall_cnt_d;
      stall_err_q <= stall_err_d;
    end
  end

  assign stall_err = stall_err_q;
`else
  // No stall monitor in this build.
`endif

endmodule

// File: tb/tb_router_wrr_arbiter.sv
module tb_router_wrr_arbiter;

  localparam int unsigned NReq = 5;
  localparam int unsigned Ww   = 4;

  logic               clk;
  logic               nreset;
  logic [NReq-1:0]    req;
  logic [NReq-1:0]    last;
  logic               out_ready;
  logic [NReq*Ww-1:0] cfg_weight;
  logic [NReq-1:0]    grant;
  logic [2:0]         grant_idx;
  logic               busy;
  logic               sel_valid;
  logic [NReq-1:0]    rd_en;
`ifdef ARB_TIMEOUT_EN
  logic               stall_err;
`endif

`ifdef ARB_TIMEOUT_EN
  router_wrr_arbiter #(.N_REQ(NReq), .WEIGHT_W(Ww), .TIMEOUT_CYC(16)) dut (
`else
  router_wrr_arbiter #(.N_REQ(NReq), .WEIGHT_W(Ww)) dut (
`endif
    .clk        (clk),
    .nreset     (nreset),
    .req        (req),
    .last       (last),
    .out_ready  (out_ready),
    .cfg_weight (cfg_weight),
    .grant      (grant),
    .grant_idx  (grant_idx),
    .busy       (busy),
    .sel_valid  (sel_valid),
    .rd_en      (rd_en)
`ifdef ARB_TIMEOUT_EN
    , .stall_err (stall_err)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_err    = 0;

  // Expected pop order (input index per transferred flit).
  int exp_q[$];

  // Upstream FIFO model.
  int              pkts[NReq];
  int              flits[NReq];
  int              plen[NReq];
  logic [NReq-1:0] hold;

  int              npops;
  logic [NReq-1:0] s_grant;
  logic            s_busy;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Monitor: every pop the DUT presents is matched against the scoreboard.
  always @(negedge clk) begin
    if (nreset && rd_en != '0) begin
      if (exp_q.size() == 0) begin
        chk("unexpected_pop", 32'(rd_en), 32'd0);
      end else begin
        int e;
        e = exp_q.pop_front();
        chk("pop_owner", 32'(rd_en), 32'(1) << e);
        chk("pop_gating", {30'd0, out_ready, req[e]}, 32'd3);
      end
    end
  end

  task automatic drive();
    for (int i = 0; i < NReq; i++) begin
      req[i]  = (pkts[i] > 0) && !hold[i];
      last[i] = (flits[i] == 1);
    end
  endtask

  task automatic load(input int i, input int n, input int len);
    pkts[i]  = n;
    plen[i]  = len;
    flits[i] = len;
    drive();
  endtask

  task automatic set_w(input int i, input logic [Ww-1:0] v);
    cfg_weight[i*Ww +: Ww] = v;
  endtask

  task automatic step();
    logic [NReq-1:0] pop;
    @(negedge clk);
    pop     = rd_en;
    s_grant = grant;
    s_busy  = busy;
    @(posedge clk);
    #1;
    for (int i = 0; i < NReq; i++) begin
      if (pop[i]) begin
        flits[i]--;
        if (flits[i] == 0) begin
          pkts[i]--;
          flits[i] = plen[i];
        end
      end
    end
    if (pop != '0) npops++;
    drive();
  endtask

  task automatic clear_model();
    for (int i = 0; i < NReq; i++) begin
      pkts[i]  = 0;
      flits[i] = 0;
      plen[i]  = 1;
    end
    hold  = '0;
    npops = 0;
    exp_q.delete();
    drive();
  endtask

  task automatic do_reset();
    nreset    = 1'b0;
    out_ready = 1'b1;
    cfg_weight = {NReq{4'd1}};
    clear_model();
    @(posedge clk);
    #1;
    chk("rst_grant", 32'(grant), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_grant_idx", 32'(grant_idx), 32'd0);
    chk("rst_rd_en", 32'(rd_en), 32'd0);
    nreset = 1'b1;
  endtask

  task automatic run_pops(input int target, input int max_cyc, output int cyc);
    cyc = 0;
    while (npops < target && cyc < max_cyc) begin
      step();
      cyc++;
    end
    if (npops < target) chk("pop_timeout", 32'(npops), 32'(target));
  endtask

  task automatic drain_check(input string name);
    step();
    step();
    chk(name, 32'(exp_q.size()), 32'd0);
  endtask

  int cyc;

  initial begin
    nreset = 1'b0;
    req = '0;
    last = '0;
    out_ready = 1'b0;
    cfg_weight = '0;

    // Single input, 3-flit packet, grant latency and release.
    do_reset();
    load(0, 1, 3);
    exp_q.push_back(0); exp_q.push_back(0); exp_q.push_back(0);
    step();
    chk("t1_no_grant_yet", 32'(s_grant), 32'd0);
    step();
    chk("t1_grant", 32'(s_grant), 32'h01);
    chk("t1_busy", 32'(s_busy), 32'd1);
    step();
    step();
    step();
    chk("t1_busy_fall", 32'(s_busy), 32'd0);
    chk("t1_grant_clr", 32'(s_grant), 32'd0);
    chk("t1_pops", 32'(npops), 32'd3);
    // ptr is now 1: input 1 wins over input 0.
    load(0, 1, 1);
    load(1, 1, 1);
    exp_q.push_back(1); exp_q.push_back(0);
    run_pops(5, 20, cyc);
    drain_check("t1_drain");

    // All weights 1, all requesting, 1-flit packets: strict rotation, one bubble each.
    do_reset();
    for (int i = 0; i < NReq; i++) load(i, 2, 1);
    for (int r = 0; r < 2; r++) for (int i = 0; i < NReq; i++) exp_q.push_back(i);
    run_pops(10, 100, cyc);
    chk("t2_spacing", 32'(cyc), 32'd20);
    drain_check("t2_drain");

    // Weight 3 on input 0: 0,0,0,1,0,0,0,1 with 2-flit packets.
    do_reset();
    set_w(0, 4'd3);
    load(0, 6, 2);
    load(1, 2, 2);
    for (int r = 0; r < 2; r++) begin
      for (int p = 0; p < 3; p++) begin
        exp_q.push_back(0); exp_q.push_back(0);
      end
      exp_q.push_back(1); exp_q.push_back(1);
    end
    run_pops(16, 200, cyc);
    drain_check("t3_drain");

    // Lock on input 2 with out_ready toggling and req[2] dropping mid-packet.
    do_reset();
    load(2, 1, 4);
    exp_q.push_back(2); exp_q.push_back(2); exp_q.push_back(2); exp_q.push_back(2);
    exp_q.push_back(0);
    step();
    load(0, 1, 1);
    for (int k = 0; k < 40 && npops < 5; k++) begin
      out_ready = (k % 4 == 0) || (k % 4 == 3);
      hold[2]   = (k == 3) || (k == 4);
      drive();
      step();
      if (npops < 4) chk("t4_lock_held", 32'(s_grant), 32'h04);
    end
    chk("t4_pops", 32'(npops), 32'd5);
    out_ready = 1'b1;
    drain_check("t4_drain");

    // Weight 0 behaves as 1.
    do_reset();
    set_w(3, 4'd0);
    load(3, 2, 1);
    load(4, 1, 1);
    exp_q.push_back(3); exp_q.push_back(4); exp_q.push_back(3);
    run_pops(3, 40, cyc);
    drain_check("t5_drain");

`ifdef ARB_TIMEOUT_EN
    // Stall monitor: 15 stalled cycles are tolerated, 16 set the sticky flag.
    do_reset();
    out_ready = 1'b0;
    load(1, 1, 2);
    exp_q.push_back(1); exp_q.push_back(1);
    step();
    for (int k = 0; k < 15; k++) step();
    chk("to_15_no_err", 32'(stall_err), 32'd0);
    out_ready = 1'b1;
    step();
    out_ready = 1'b0;
    for (int k = 0; k < 16; k++) step();
    chk("to_16_err", 32'(stall_err), 32'd1);
    out_ready = 1'b1;
    step();
    step();
    chk("to_sticky", 32'(stall_err), 32'd1);
    chk("to_released", 32'(s_busy), 32'd0);
    drain_check("to_drain");
`endif

    // Reset asserted mid-packet clears everything at once.
    do_reset();
    load(1, 1, 3);
    exp_q.push_back(1);
    step();
    step();
    chk("mr_locked", 32'(grant), 32'h02);
    nreset = 1'b0;
    #1;
    chk("mr_grant", 32'(grant), 32'd0);
    chk("mr_busy", 32'(busy), 32'd0);
    chk("mr_sel_valid", 32'(sel_valid), 32'd0);
    chk("mr_rd_en", 32'(rd_en), 32'd0);
`ifdef ARB_TIMEOUT_EN
    chk("mr_stall_err", 32'(stall_err), 32'd0);
`endif
    chk("mr_scoreboard", 32'(exp_q.size()), 32'd0);
    clear_model();
    @(posedge clk);
    #1;
    nreset = 1'b1;

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule
